// File: rtl/pt_check_if.sv
// pt_check_if -- handshake and PT-memory read bus for pt_check.
//
//   en        requester -> checker   start request, sampled only while rdy=1
//   rdy       checker -> requester   1 = idle, results stable
//   pt_addr   checker -> PT memory   read address
//   pt_rddata PT memory -> checker   read data, one cycle after pt_addr
//   valid     checker -> requester   ok/len_out hold a completed result
//   ok        checker -> requester   1 = every message byte in range
//   len_out   checker -> requester   message length L from PT[0]
//   bad_idx   checker -> requester   first out-of-range index
//                                    (present only with PT_CHECK_BADIDX_EN)
//
// The slave modport is the checker; the master modport is the requester
// together with the PT memory read port.
interface pt_check_if;
    logic       en;
    logic       rdy;
    logic [7:0] pt_addr;
    logic [7:0] pt_rddata;
    logic       valid;
    logic       ok;
    logic [7:0] len_out;
`ifdef PT_CHECK_BADIDX_EN
    logic [7:0] bad_idx;

    modport slave  (input  en, pt_rddata,
                    output rdy, pt_addr, valid, ok, len_out, bad_idx);
    modport master (output en, pt_rddata,
                    input  rdy, pt_addr, valid, ok, len_out, bad_idx);
`else
    modport slave  (input  en, pt_rddata,
                    output rdy, pt_addr, valid, ok, len_out);
    modport master (output en, pt_rddata,
                    input  rdy, pt_addr, valid, ok, len_out);
`endif
endinterface

// File: rtl/pt_check.sv
// pt_check -- validates decrypted plaintext left in PT memory by arc4.
//
// PT layout: byte 0 is the length L, bytes 1..L are the message. The result
// is ok=1 when every message byte lies in [LO_CHAR, HI_CHAR] (L=0 is ok).
// Scanning stops at the first bad byte. PT memory is only ever read.
//
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    pt_check_if.slave: en/rdy handshake, PT read port
//          (pt_addr/pt_rddata), results valid/ok/len_out[/bad_idx]
//
// Parameters:
//   LO_CHAR  lowest accepted byte, inclusive
//   HI_CHAR  highest accepted byte, inclusive (LO_CHAR <= HI_CHAR)
//
// Build option:
//   PT_CHECK_BADIDX_EN  when defined, adds the bad_idx output and register
//                       (index of the first out-of-range byte on a failed run).
module pt_check #(
    parameter logic [7:0] LO_CHAR = 8'h20,
    parameter logic [7:0] HI_CHAR = 8'h7E
) (
    input  logic      clk,
    input  logic      rst_n,
    pt_check_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LEN, SCAN} state_t;

    state_t     state, state_nx;
    logic [7:0] cnt;
    logic [7:0] len_q;
    logic       valid_q;
    logic       ok_q;

    // Shared decision terms so the FSM and the datapath cannot disagree.
    logic accept;
    logic len_zero;
    logic byte_bad;
    logic last_byte;

    assign accept    = (state == IDLE) && bus.en;
    assign len_zero  = (bus.pt_rddata == 8'd0);
    assign byte_bad  = (bus.pt_rddata < LO_CHAR) || (bus.pt_rddata > HI_CHAR);
    // len_q is already loaded while in SCAN, so the last-byte test uses it.
    assign last_byte = (cnt == len_q);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.en) state_nx = LEN;
            LEN:     state_nx = len_zero ? IDLE : SCAN;
            SCAN:    if (byte_bad || last_byte) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- outputs from state ----------------
    // Address is one ahead of the byte being judged because the RAM returns
    // data a cycle after the address. In IDLE PT[0] is pre-read so the length
    // is already on pt_rddata in LEN. At cnt=255 the address wraps to 0; that
    // read is never consumed since cnt=255 is always the final byte.
    always_comb begin
        bus.rdy     = 1'b0;
        bus.pt_addr = 8'd0;
        case (state)
            IDLE:    begin bus.rdy = 1'b1; bus.pt_addr = 8'd0; end
            LEN:     bus.pt_addr = 8'd1;
            SCAN:    bus.pt_addr = cnt + 8'd1;
            default: begin bus.rdy = 1'b0; bus.pt_addr = 8'd0; end
        endcase
    end

    // ---------------- result / counter datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= 8'd0;
            len_q   <= 8'd0;
            valid_q <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        valid_q <= 1'b0;
                        ok_q    <= 1'b0;
                    end
                end
                LEN: begin
                    len_q <= bus.pt_rddata;
                    if (len_zero) begin
                        ok_q    <= 1'b1;
                        valid_q <= 1'b1;
                    end else begin
                        cnt <= 8'd1;
                    end
                end
                SCAN: begin
                    if (byte_bad) begin
                        ok_q    <= 1'b0;
                        valid_q <= 1'b1;
                    end else if (last_byte) begin
                        ok_q    <= 1'b1;
                        valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.valid   = valid_q;
    assign bus.ok      = ok_q;
    assign bus.len_out = len_q;

`ifdef PT_CHECK_BADIDX_EN
    logic [7:0] bad_q;

    // Records the failing index; cleared on accept and on any ok result so a
    // stale index never accompanies ok=1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bad_q <= 8'd0;
        end else begin
            case (state)
                IDLE:    if (accept) bad_q <= 8'd0;
                LEN:     if (len_zero) bad_q <= 8'd0;
                SCAN: begin
                    if (byte_bad)       bad_q <= cnt;
                    else if (last_byte) bad_q <= 8'd0;
                end
                default: ;
            endcase
        end
    end

    assign bus.bad_idx = bad_q;
`endif

endmodule
